// File: rtl/cc3000_fpga_mss.sv
// SmartFusion MSS stand-in: UART_0 command parser driving an APB3 master, SPI_1 master and GPOs.
// Optional macro CC3000_APB_TIMEOUT_EN bounds the APB access phase to APB_TIMEOUT cycles.
module cc3000_fpga_mss #(
   parameter int CLK_DIV     = 87,
   parameter int SPI_DIV     = 4,
   parameter int APB_TIMEOUT = 256
) (
   input  logic        SYSCLK,
   input  logic        MSS_RESET_N,
   output logic        FAB_CLK,
   output logic        M2F_RESET_N,
   output logic        MSSPSEL,
   output logic        MSSPENABLE,
   output logic        MSSPWRITE,
   output logic [19:0] MSSPADDR,
   output logic [31:0] MSSPWDATA,
   input  logic [31:0] MSSPRDATA,
   input  logic        MSSPREADY,
   input  logic        MSSPSLVERR,
   input  logic        UART_0_RXD,
   output logic        UART_0_TXD,
   input  logic        UART_1_RXD,
   output logic        UART_1_TXD,
   input  logic        SPI_1_DI,
   output logic        SPI_1_DO,
   inout  wire         SPI_1_CLK,
   inout  wire         SPI_1_SS,
   input  logic        GPIO_2_IN,
   output logic        M2F_GPO_0,
   output logic        M2F_GPO_1,
   output logic        M2F_GPO_3,
   output logic        M2F_GPO_9,
   output logic        GPIO_4_OUT
);

   localparam int CW  = $clog2(CLK_DIV) + 1;
   localparam int SW  = $clog2(SPI_DIV) + 1;
   localparam int TOW = $clog2(APB_TIMEOUT) + 1;
`ifdef CC3000_APB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_S = 8'h53;

   typedef enum logic [2:0] {
      ST_IDLE, ST_ARGS, ST_SETUP, ST_ACCESS, ST_SPI_GO, ST_SPI_WAIT, ST_REPLY
   } state_t;

   // ---------------- reset / sync / loopback ----------------
   logic [1:0] rst_sync_reg;
   logic [1:0] gpio_sync_reg;
   logic [1:0] u1_reg;

   always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         rst_sync_reg  <= 2'b00;
         gpio_sync_reg <= 2'b00;
         u1_reg        <= 2'b11;
      end else begin
         rst_sync_reg  <= {rst_sync_reg[0], 1'b1};
         gpio_sync_reg <= {gpio_sync_reg[0], GPIO_2_IN};
         u1_reg        <= {u1_reg[0], UART_1_RXD};
      end
   end

   assign FAB_CLK     = SYSCLK;
   assign M2F_RESET_N = rst_sync_reg[1];
   assign UART_1_TXD  = u1_reg[1];

   // ---------------- UART_0 receiver ----------------
   // rx_bit_reg: 0 idle, 1 start check, 2..9 data bits, 10 stop bit
   logic [2:0]    rx_sync_reg;
   logic [3:0]    rx_bit_reg;
   logic [CW-1:0] rx_cnt_reg;
   logic [7:0]    rx_data_reg;
   logic          rx_valid_reg;
   logic          rx_err_reg;

   always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         rx_sync_reg  <= 3'b111;
         rx_bit_reg   <= 4'd0;
         rx_cnt_reg   <= '0;
         rx_data_reg  <= 8'h00;
         rx_valid_reg <= 1'b0;
         rx_err_reg   <= 1'b0;
      end else begin
         rx_sync_reg  <= {rx_sync_reg[1:0], UART_0_RXD};
         rx_valid_reg <= 1'b0;
         rx_err_reg   <= 1'b0;
         if (rx_bit_reg == 4'd0) begin
            if (rx_sync_reg[2] && !rx_sync_reg[1]) begin
               rx_bit_reg <= 4'd1;
               rx_cnt_reg <= CW'(CLK_DIV / 2);
            end
         end else if (rx_cnt_reg != '0) begin
            rx_cnt_reg <= rx_cnt_reg - 1'b1;
         end else begin
            rx_cnt_reg <= CW'(CLK_DIV - 1);
            if (rx_bit_reg == 4'd1) begin
               rx_bit_reg <= rx_sync_reg[1] ? 4'd0 : 4'd2;
            end else if (rx_bit_reg == 4'd10) begin
               rx_bit_reg   <= 4'd0;
               rx_valid_reg <= rx_sync_reg[1];
               rx_err_reg   <= !rx_sync_reg[1];
            end else begin
               rx_data_reg <= {rx_sync_reg[1], rx_data_reg[7:1]};
               rx_bit_reg  <= rx_bit_reg + 4'd1;
            end
         end
      end
   end

   // ---------------- UART_0 transmitter ----------------
   logic          tx_go;
   logic [7:0]    tx_byte;
   logic          tx_busy_reg;
   logic [8:0]    tx_sh_reg;
   logic [3:0]    tx_bits_reg;
   logic [CW-1:0] tx_cnt_reg;

   always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         tx_busy_reg <= 1'b0;
         tx_sh_reg   <= 9'h1FF;
         tx_bits_reg <= 4'd0;
         tx_cnt_reg  <= '0;
      end else if (tx_go) begin
         tx_busy_reg <= 1'b1;
         tx_sh_reg   <= {tx_byte, 1'b0};
         tx_bits_reg <= 4'd9;
         tx_cnt_reg  <= CW'(CLK_DIV - 1);
      end else if (tx_busy_reg) begin
         if (tx_cnt_reg != '0) begin
            tx_cnt_reg <= tx_cnt_reg - 1'b1;
         end else begin
            tx_cnt_reg <= CW'(CLK_DIV - 1);
            if (tx_bits_reg == 4'd0) begin
               tx_busy_reg <= 1'b0;
            end else begin
               tx_sh_reg   <= {1'b1, tx_sh_reg[8:1]};
               tx_bits_reg <= tx_bits_reg - 4'd1;
            end
         end
      end
   end

   assign UART_0_TXD = tx_busy_reg ? tx_sh_reg[0] : 1'b1;

   // ---------------- SPI_1 master, mode 0 ----------------
   // Even half-period steps raise the clock, odd ones lower it; step 16 closes SS.
   logic          spi_go;
   logic [31:0]   wdata_reg;
   logic          spi_busy_reg;
   logic [4:0]    spi_step_reg;
   logic [SW-1:0] spi_div_reg;
   logic [7:0]    spi_tx_reg;
   logic [7:0]    spi_rx_reg;
   logic          spi_clk_reg;
   logic          spi_ss_reg;
   logic          spi_do_reg;

   always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         spi_busy_reg <= 1'b0;
         spi_step_reg <= 5'd0;
         spi_div_reg  <= '0;
         spi_tx_reg   <= 8'h00;
         spi_rx_reg   <= 8'h00;
         spi_clk_reg  <= 1'b0;
         spi_ss_reg   <= 1'b1;
         spi_do_reg   <= 1'b0;
      end else if (spi_go) begin
         spi_busy_reg <= 1'b1;
         spi_ss_reg   <= 1'b0;
         spi_tx_reg   <= wdata_reg[7:0];
         spi_do_reg   <= wdata_reg[7];
         spi_step_reg <= 5'd0;
         spi_div_reg  <= SW'(SPI_DIV - 1);
      end else if (spi_busy_reg) begin
         if (spi_div_reg != '0) begin
            spi_div_reg <= spi_div_reg - 1'b1;
         end else begin
            spi_div_reg  <= SW'(SPI_DIV - 1);
            spi_step_reg <= spi_step_reg + 5'd1;
            if (spi_step_reg == 5'd16) begin
               spi_ss_reg   <= 1'b1;
               spi_busy_reg <= 1'b0;
               spi_do_reg   <= 1'b0;
            end else if (!spi_step_reg[0]) begin
               spi_clk_reg <= 1'b1;
               spi_rx_reg  <= {spi_rx_reg[6:0], SPI_1_DI};
            end else begin
               spi_clk_reg <= 1'b0;
               spi_tx_reg  <= {spi_tx_reg[6:0], 1'b0};
               spi_do_reg  <= spi_tx_reg[6];
            end
         end
      end
   end

   assign SPI_1_CLK = spi_clk_reg;
   assign SPI_1_SS  = spi_ss_reg;
   assign SPI_1_DO  = spi_do_reg;

   // ---------------- command parser / APB master ----------------
   state_t         state_reg, state_next;
   logic [7:0]     cmd_reg, cmd_next;
   logic [2:0]     argcnt_reg, argcnt_next;
   logic [19:0]    addr_reg, addr_next;
   logic [31:0]    wdata_next;
   logic [31:0]    rdata_reg, rdata_next;
   logic           slverr_reg, slverr_next;
   logic           tmo_reg, tmo_next;
   logic [TOW-1:0] tocnt_reg, tocnt_next;
   logic [2:0]     ridx_reg, ridx_next;
   logic [2:0]     rlen_reg, rlen_next;
   logic [4:0]     gpo_reg, gpo_next;
   logic [2:0]     last_arg;
   logic [7:0]     status;

   always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         state_reg  <= ST_IDLE;
         cmd_reg    <= 8'h00;
         argcnt_reg <= 3'd0;
         addr_reg   <= 20'h0;
         wdata_reg  <= 32'h0;
         rdata_reg  <= 32'h0;
         slverr_reg <= 1'b0;
         tmo_reg    <= 1'b0;
         tocnt_reg  <= '0;
         ridx_reg   <= 3'd0;
         rlen_reg   <= 3'd0;
         gpo_reg    <= 5'd0;
      end else begin
         state_reg  <= state_next;
         cmd_reg    <= cmd_next;
         argcnt_reg <= argcnt_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         rdata_reg  <= rdata_next;
         slverr_reg <= slverr_next;
         tmo_reg    <= tmo_next;
         tocnt_reg  <= tocnt_next;
         ridx_reg   <= ridx_next;
         rlen_reg   <= rlen_next;
         gpo_reg    <= gpo_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cmd_next    = cmd_reg;
      argcnt_next = argcnt_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      rdata_next  = rdata_reg;
      slverr_next = slverr_reg;
      tmo_next    = tmo_reg;
      tocnt_next  = tocnt_reg;
      ridx_next   = ridx_reg;
      rlen_next   = rlen_reg;
      gpo_next    = gpo_reg;
      tx_go       = 1'b0;
      spi_go      = 1'b0;
      last_arg    = (cmd_reg == CMD_W) ? 3'd6 : (cmd_reg == CMD_R) ? 3'd2 : 3'd0;
      status      = {5'b0, gpio_sync_reg[1], tmo_reg, slverr_reg};

      tx_byte = status;
      if (cmd_reg == CMD_R && ridx_reg < 3'd4)
         tx_byte = rdata_reg[{ridx_reg[1:0], 3'b000} +: 8];
      else if (cmd_reg == CMD_S && ridx_reg == 3'd0)
         tx_byte = spi_rx_reg;

      case (state_reg)
         ST_IDLE: begin
            if (rx_valid_reg && (rx_data_reg == CMD_W || rx_data_reg == CMD_R ||
                                 rx_data_reg == CMD_G || rx_data_reg == CMD_S)) begin
               cmd_next    = rx_data_reg;
               argcnt_next = 3'd0;
               slverr_next = 1'b0;
               tmo_next    = 1'b0;
               ridx_next   = 3'd0;
               state_next  = ST_ARGS;
            end
         end
         ST_ARGS: begin
            if (rx_err_reg) begin
               state_next = ST_IDLE;
            end else if (rx_valid_reg) begin
               argcnt_next = argcnt_reg + 3'd1;
               // address bytes arrive first, LSB first; the top nibble of byte 2 is dropped
               if ((cmd_reg == CMD_W || cmd_reg == CMD_R) && argcnt_reg < 3'd3) begin
                  if (argcnt_reg == 3'd0)      addr_next[7:0]   = rx_data_reg;
                  else if (argcnt_reg == 3'd1) addr_next[15:8]  = rx_data_reg;
                  else                         addr_next[19:16] = rx_data_reg[3:0];
               end else if (cmd_reg == CMD_W) begin
                  wdata_next[{argcnt_reg[1:0] + 2'd1, 3'b000} +: 8] = rx_data_reg;
               end else begin
                  wdata_next[7:0] = rx_data_reg;
               end
               if (argcnt_reg == last_arg) begin
                  if (cmd_reg == CMD_W || cmd_reg == CMD_R) begin
                     state_next = ST_SETUP;
                  end else if (cmd_reg == CMD_G) begin
                     gpo_next   = rx_data_reg[4:0];
                     rlen_next  = 3'd1;
                     state_next = ST_REPLY;
                  end else begin
                     state_next = ST_SPI_GO;
                  end
               end
            end
         end
         ST_SETUP: begin
            tocnt_next = '0;
            state_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            tocnt_next = tocnt_reg + 1'b1;
            if (MSSPREADY) begin
               slverr_next = MSSPSLVERR;
               if (cmd_reg == CMD_R) rdata_next = MSSPRDATA;
               rlen_next  = (cmd_reg == CMD_R) ? 3'd5 : 3'd1;
               state_next = ST_REPLY;
            end else if (TMO_EN && tocnt_reg == TOW'(APB_TIMEOUT - 1)) begin
               tmo_next   = 1'b1;
               rdata_next = 32'h0;
               rlen_next  = (cmd_reg == CMD_R) ? 3'd5 : 3'd1;
               state_next = ST_REPLY;
            end
         end
         ST_SPI_GO: begin
            spi_go     = 1'b1;
            state_next = ST_SPI_WAIT;
         end
         ST_SPI_WAIT: begin
            if (!spi_busy_reg) begin
               rlen_next  = 3'd2;
               state_next = ST_REPLY;
            end
         end
         ST_REPLY: begin
            if (!tx_busy_reg) begin
               tx_go     = 1'b1;
               ridx_next = ridx_reg + 3'd1;
               if (ridx_reg == rlen_reg - 3'd1) state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign MSSPSEL    = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
   assign MSSPENABLE = (state_reg == ST_ACCESS);
   assign MSSPWRITE  = MSSPSEL && (cmd_reg == CMD_W);
   assign MSSPADDR   = addr_reg;
   assign MSSPWDATA  = wdata_reg;

   assign M2F_GPO_0  = gpo_reg[0];
   assign M2F_GPO_1  = gpo_reg[1];
   assign M2F_GPO_3  = gpo_reg[2];
   assign M2F_GPO_9  = gpo_reg[3];
   assign GPIO_4_OUT = gpo_reg[4];

endmodule

// File: tb/tb_cc3000_fpga_mss.sv
// Scoreboard bench for cc3000_fpga_mss: UART command stimulus, APB slave model, SPI loopback.
`timescale 1ns/1ps
module tb_cc3000_fpga_mss;
   localparam int CLK_DIV     = 87;
   localparam int SPI_DIV     = 4;
   localparam int APB_TIMEOUT = 256;

   logic        sysclk = 1'b0;
   logic        mss_reset_n = 1'b0;
   logic        fab_clk, m2f_reset_n;
   logic        psel, penable, pwrite;
   logic [19:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata = 32'h0;
   logic        pready = 1'b0;
   logic        pslverr = 1'b0;
   logic        u0_rxd = 1'b1, u0_txd;
   logic        u1_rxd = 1'b1, u1_txd;
   logic        spi_do;
   wire         spi_clk, spi_ss;
   logic        gpio_2_in = 1'b0;
   logic        gpo0, gpo1, gpo3, gpo9, gpio4;

   always #50 sysclk = ~sysclk;

   cc3000_fpga_mss #(.CLK_DIV(CLK_DIV), .SPI_DIV(SPI_DIV), .APB_TIMEOUT(APB_TIMEOUT)) dut (
      .SYSCLK(sysclk), .MSS_RESET_N(mss_reset_n), .FAB_CLK(fab_clk), .M2F_RESET_N(m2f_reset_n),
      .MSSPSEL(psel), .MSSPENABLE(penable), .MSSPWRITE(pwrite), .MSSPADDR(paddr),
      .MSSPWDATA(pwdata), .MSSPRDATA(prdata), .MSSPREADY(pready), .MSSPSLVERR(pslverr),
      .UART_0_RXD(u0_rxd), .UART_0_TXD(u0_txd), .UART_1_RXD(u1_rxd), .UART_1_TXD(u1_txd),
      .SPI_1_DI(spi_do), .SPI_1_DO(spi_do), .SPI_1_CLK(spi_clk), .SPI_1_SS(spi_ss),
      .GPIO_2_IN(gpio_2_in), .M2F_GPO_0(gpo0), .M2F_GPO_1(gpo1), .M2F_GPO_3(gpo3),
      .M2F_GPO_9(gpo9), .GPIO_4_OUT(gpio4)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [19:0] addr;
      logic        wr;
      logic [31:0] wdata;
   } apb_t;

   logic [7:0] reply_q[$];
   apb_t       apb_q[$];

   // APB slave: PREADY after apb_wait access cycles, checks against the expected transfer
   int   apb_wait = 0;
   int   acc_cnt  = 0;
   int   acc_len  = 0;
   logic prev_setup = 1'b0;
   apb_t apb_exp;

   initial forever begin
      @(negedge sysclk);
      if (psel && penable) begin
         if (acc_cnt == 0) check("apb_setup", 32'(prev_setup), 32'd1);
         if (acc_cnt >= apb_wait) begin
            pready = 1'b1;
            if (acc_cnt == apb_wait) begin
               if (apb_q.size() == 0) begin
                  check("apb_unexpected", 32'(apb_q.size()), 32'd1);
               end else begin
                  apb_exp = apb_q.pop_front();
                  check("apb_addr", 32'(paddr), 32'(apb_exp.addr));
                  check("apb_write", 32'(pwrite), 32'(apb_exp.wr));
                  if (apb_exp.wr) check("apb_wdata", pwdata, apb_exp.wdata);
               end
            end
         end
         acc_cnt++;
      end else begin
         if (acc_cnt != 0) acc_len = acc_cnt;
         acc_cnt = 0;
         pready  = 1'b0;
      end
      prev_setup = psel && !penable;
   end

   // UART_0 reply receiver pops the scoreboard
   logic [7:0] rx_b;
   initial forever begin
      @(negedge u0_txd);
      repeat (CLK_DIV / 2) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         repeat (CLK_DIV) @(negedge sysclk);
         rx_b[i] = u0_txd;
      end
      repeat (CLK_DIV) @(negedge sysclk);
      check("reply_stop", 32'(u0_txd), 32'd1);
      if (reply_q.size() == 0) check("reply_extra", 32'(rx_b), 32'h100);
      else                     check("reply", 32'(rx_b), 32'(reply_q.pop_front()));
   end

   // SPI monitor: capture DO on each rising SPI clock
   logic [7:0] spi_cap = 8'h00;
   int         spi_edges = 0;
   int         ss_err = 0;
   initial forever begin
      @(posedge spi_clk);
      spi_cap = {spi_cap[6:0], spi_do};
      spi_edges++;
      if (spi_ss !== 1'b0) ss_err++;
   end

   task automatic uart_send(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         u0_rxd = frame[i];
         repeat (CLK_DIV) @(negedge sysclk);
      end
      u0_rxd = 1'b1;
   endtask

   task automatic wait_replies(input string tag);
      int n;
      n = 0;
      while (reply_q.size() != 0 && n < 40000) begin
         @(negedge sysclk);
         n++;
      end
      check({tag, "_timeout"}, 32'(reply_q.size()), 32'd0);
      reply_q.delete();
      repeat (2 * CLK_DIV) @(negedge sysclk);
   endtask

   task automatic cmd_gpo(input logic [7:0] b);
      $display("txn G arg=%h", b);
      reply_q.push_back({5'b0, gpio_2_in, 2'b00});
      uart_send(8'h47, 1'b1);
      uart_send(b, 1'b1);
      wait_replies("gpo");
      check("gpo", 32'({gpio4, gpo9, gpo3, gpo1, gpo0}), 32'(b[4:0]));
   endtask

   task automatic cmd_write(input logic [23:0] a, input logic [31:0] d, input logic se, input int w);
      $display("txn W addr=%h data=%h slverr=%0d wait=%0d", a, d, se, w);
      apb_q.push_back('{addr: a[19:0], wr: 1'b1, wdata: d});
      reply_q.push_back({5'b0, gpio_2_in, 1'b0, se});
      apb_wait = w;
      pslverr  = se;
      uart_send(8'h57, 1'b1);
      for (int i = 0; i < 3; i++) uart_send(a[8*i +: 8], 1'b1);
      for (int i = 0; i < 4; i++) uart_send(d[8*i +: 8], 1'b1);
      wait_replies("write");
      check("write_bus_idle", 32'({psel, penable, pwrite}), 32'd0);
   endtask

   task automatic cmd_read(input logic [23:0] a, input logic [31:0] d, input logic se,
                           input int w, input logic tmo);
      logic [31:0] ed;
      $display("txn R addr=%h data=%h slverr=%0d wait=%0d", a, d, se, w);
      ed = tmo ? 32'h0 : d;
      if (!tmo) apb_q.push_back('{addr: a[19:0], wr: 1'b0, wdata: 32'h0});
      for (int i = 0; i < 4; i++) reply_q.push_back(ed[8*i +: 8]);
      reply_q.push_back({5'b0, gpio_2_in, tmo, tmo ? 1'b0 : se});
      apb_wait = w;
      prdata   = d;
      pslverr  = se;
      uart_send(8'h52, 1'b1);
      for (int i = 0; i < 3; i++) uart_send(a[8*i +: 8], 1'b1);
      wait_replies("read");
      check("read_bus_idle", 32'({psel, penable, pwrite}), 32'd0);
   endtask

   task automatic cmd_spi(input logic [7:0] b);
      $display("txn S arg=%h", b);
      spi_edges = 0;
      ss_err    = 0;
      reply_q.push_back(b);
      reply_q.push_back({5'b0, gpio_2_in, 2'b00});
      uart_send(8'h53, 1'b1);
      uart_send(b, 1'b1);
      wait_replies("spi");
      check("spi_do_bits", 32'(spi_cap), 32'(b));
      check("spi_edges", 32'(spi_edges), 32'd8);
      check("spi_ss_low", 32'(ss_err), 32'd0);
      check("spi_idle", 32'({spi_ss, spi_clk}), 32'b10);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_apb"}, 32'({psel, penable, pwrite}), 32'd0);
      check({tag, "_paddr"}, 32'(paddr), 32'd0);
      check({tag, "_pwdata"}, pwdata, 32'd0);
      check({tag, "_txd"}, 32'({u0_txd, u1_txd}), 32'b11);
      check({tag, "_spi"}, 32'({spi_clk, spi_ss, spi_do}), 32'b010);
      check({tag, "_gpo"}, 32'({gpio4, gpo9, gpo3, gpo1, gpo0}), 32'd0);
      check({tag, "_m2f"}, 32'(m2f_reset_n), 32'd0);
   endtask

   task automatic release_reset();
      @(negedge sysclk);
      mss_reset_n = 1'b1;
      @(posedge sysclk); #1;
      check("m2f_edge1", 32'(m2f_reset_n), 32'd0);
      @(posedge sysclk); #1;
      check("m2f_edge2", 32'(m2f_reset_n), 32'd1);
      $display("txn reset released");
   endtask

   initial begin
      repeat (3) @(negedge sysclk);
      check_reset_outputs("reset");
      release_reset();

      gpio_2_in = 1'b1;
      cmd_gpo(8'h1F);

      gpio_2_in = 1'b0;
      cmd_write(24'h001000, 32'hDEADBEEF, 1'b0, 0);
      cmd_read(24'h000020, 32'h12345678, 1'b1, 3, 1'b0);
      check("acc_len_wait3", 32'(acc_len), 32'd4);
      cmd_write(24'hF34567, 32'h0BADF00D, 1'b0, 2);
      check("acc_len_wait2", 32'(acc_len), 32'd3);

      gpio_2_in = 1'b1;
      cmd_spi(8'hA5);
      gpio_2_in = 1'b0;
      cmd_spi(8'h3C);

      // a framing error inside ARGS returns the parser to idle
      cmd_gpo(8'h0A);
      $display("txn G with framing error");
      uart_send(8'h47, 1'b1);
      uart_send(8'h1F, 1'b0);
      repeat (CLK_DIV) @(negedge sysclk);
      uart_send(8'h1F, 1'b1);
      repeat (14 * CLK_DIV) @(negedge sysclk);
      check("frame_err_gpo", 32'({gpio4, gpo9, gpo3, gpo1, gpo0}), 32'h0A);

      $display("txn UART_1 loopback");
      @(negedge sysclk);
      u1_rxd = 1'b0;
      @(posedge sysclk); #1;
      check("u1_delay1", 32'(u1_txd), 32'd1);
      @(posedge sysclk); #1;
      check("u1_delay2", 32'(u1_txd), 32'd0);
      u1_rxd = 1'b1;
      repeat (3) @(negedge sysclk);

`ifdef CC3000_APB_TIMEOUT_EN
      cmd_read(24'h000040, 32'hCAFEF00D, 1'b0, 1000000, 1'b1);
      check("acc_len_timeout", 32'(acc_len), 32'(APB_TIMEOUT));
`endif

      // reset in the middle of a write command
      $display("txn reset during W");
      uart_send(8'h57, 1'b1);
      uart_send(8'h11, 1'b1);
      @(negedge sysclk);
      mss_reset_n = 1'b0;
      #10;
      check_reset_outputs("midreset");
      repeat (2) @(negedge sysclk);
      release_reset();
      cmd_gpo(8'h15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
